debug_hex_scanner: RTL and testbench
====================================

# debug_hex_scanner

Multi-channel debug readout engine for the VGA debug overlay. It snapshots up to SEQ_NUM signed or unsigned debug values on a frame-synchronous tick and converts each one serially into sign-plus-hex display codes. Results go into a double-buffered digit store that the pixel generator reads combinationally by (channel, digit). It replaces the per-value combinational font expansion with one shared sequential converter, so the on-screen readout never tears mid-frame.

## Interface
Parameters:
- SEQ_NUM, 4: number of debug channels (≥1).
- SEQ_LEN, 16: bits per channel; must be a multiple of 4.
- SIGNED_MASK, all ones (SEQ_NUM bits): bit c=1 means channel c is two's complement; bit c=0 means unsigned.
- ZERO_SUPPRESS, 0: when 1, leading zero nibbles display as blank.
- Derived, not overridable:
  - SEQ_DIGITS = SEQ_LEN/4+1 (one sign slot plus the nibbles).
  - CH_W = $clog2(SEQ_NUM), minimum 1.
  - DIG_W = $clog2(SEQ_DIGITS).

Ports:
- sys_clk  in  1  sole clock.
- sys_rst_n  in  1  reset, asynchronous, active-low.
- sample_tick  in  1  single-cycle request to snapshot and convert (e.g. frame start).
- freeze  in  1  level; while high, new ticks are ignored.
- seq_in  in  SEQ_NUM*SEQ_LEN  channel c at [c*SEQ_LEN +: SEQ_LEN].
- rd_ch  in  CH_W  read channel select.
- rd_digit  in  DIG_W  read digit index; 0 = sign slot (leftmost), 1..SEQ_DIGITS-1 = nibbles, MS first.
- rd_code  out  5  display code:
  - 0–15 = hex digit.
  - 16 = minus.
  - 17 = blank.
- busy  out  1  conversion in progress.
- update  out  1  one-cycle pulse; the new front buffer is visible.
- overrun  out  1  one-cycle pulse; a tick was dropped because busy was high.

## Operation
- States:
  - IDLE: if sample_tick and !freeze, register all of seq_in into the snapshot, set ch=0, go to LOAD. Ticks with freeze high are silently ignored.
  - LOAD (1 cycle per channel):
    - neg = SIGNED_MASK[ch] & snapshot[ch][MSB].
    - mag = neg ? -snapshot : snapshot, computed SEQ_LEN+1 bits wide.
    - The most negative value yields magnitude 2^(SEQ_LEN-1), which fits in the nibbles.
    - Set dig=0, go to EMIT.
  - EMIT (SEQ_DIGITS cycles): write one code per cycle into the back buffer at (ch, dig).
    - dig 0 is 16 if neg, else 17.
    - dig k is nibble k of mag, MS first.
    - With ZERO_SUPPRESS, a zero nibble preceding the first nonzero nibble is written as 17. The last nibble is never suppressed.
    - At the last digit: if ch==SEQ_NUM-1 go to SWAP, else ch+1 and go to LOAD.
  - SWAP (1 cycle): toggle front select, pulse update, return to IDLE.
- busy is high in LOAD, EMIT and SWAP.
- A sample_tick while busy is dropped and pulses overrun on the next cycle.
- rd_code is a combinational read of the front buffer.
- Out-of-range rd_ch or rd_digit returns 17.
- The back buffer is never visible while it is being written.

## Timing
- Reset values:
  - Both buffers all 17.
  - Front select 0.
  - busy, update, overrun all 0.
  - State IDLE; snapshot 0.
- Latency: the tick is sampled at edge E0. update is high for the cycle after edge E0+N, where N = 1+SEQ_NUM*(1+SEQ_DIGITS). With defaults N = 25.
- The new front buffer appears on rd_code in the same cycle update is high.
- Read latency is 0 cycles.
- A tick arriving in the same cycle as update (SWAP) counts as busy: it is dropped and overrun pulses.
- A tick on the first IDLE cycle after SWAP is accepted.
- freeze rising mid-conversion does not abort; the conversion completes and swaps.
- Reset asserted mid-operation aborts immediately: buffers go blank and the FSM returns to IDLE.
- seq_in changes after the snapshot edge have no effect on the current conversion.

## Structure
- Shared package debug_pkg holds:
  - CODE_W=5, CODE_MINUS=16, CODE_BLANK=17.
  - The state enum (IDLE, LOAD, EMIT, SWAP).
- The same code constants are also used by the pixel generator's font lookup.
- One sub-module, debug_sign_mag: combinational signed flag plus value to neg and magnitude. It is reusable by the pixel generator's other readouts.
- The buffers are two register arrays of SEQ_NUM*SEQ_DIGITS entries × 5 bits; no RAM macro.

## Test plan
- ch0=16'h1234 signed, tick → update pulses 25 edges later; ch0 digits 0..4 read 17,1,2,3,4.
- ch1=16'hFFFF signed → 16,0,0,0,1. ch2=16'h8000 signed → 16,8,0,0,0. Same ch2 value with SIGNED_MASK bit 2 cleared → 17,8,0,0,0.
- ZERO_SUPPRESS=1: ch3=16'h0005 → 17,17,17,17,5. ch3=0 → 17,17,17,17,0. ch3=16'hFFF0 signed (−16) → 16,17,17,1,0.
- Second tick 5 cycles after the first → overrun pulses once, only one update follows. Tick with freeze=1 → busy stays 0, rd_code unchanged.
- Reset pulse at cycle 10 of a conversion → every rd_code reads 17, busy=0. A following tick converts normally with update after 25 edges.
- Change ch0 from 16'h0001 to 16'h0002 and tick; read continuously during the conversion → old digits 17,0,0,0,1 until the update cycle, then 17,0,0,0,2. rd_ch=4 or rd_digit=7 reads 17.

Source files
------------

// File: rtl/debug_pkg.sv
// Shared definitions for the VGA debug overlay.
//   CODE_W / CODE_MINUS / CODE_BLANK : display-code encoding shared with the
//                                      pixel generator's font lookup
//                                      (0..15 hex digit, 16 minus, 17 blank).
//   scan_state_e                     : readout engine sequencer states.
package debug_pkg;

    localparam int CODE_W = 5;
    localparam logic [CODE_W-1:0] CODE_MINUS = 5'd16;
    localparam logic [CODE_W-1:0] CODE_BLANK = 5'd17;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        EMIT = 2'd2,
        SWAP = 2'd3
    } scan_state_e;

endpackage

// File: rtl/debug_sign_mag.sv
// Signed-flag plus value to sign and magnitude.
//   is_signed  in  1    value is two's complement when high
//   value      in  W    raw value
//   neg        out 1    value is negative (only possible when is_signed)
//   mag        out W+1  absolute value; W+1 bits so the most negative input
//                       is represented exactly
module debug_sign_mag #(
    parameter int W = 16
) (
    input  logic         is_signed,
    input  logic [W-1:0] value,
    output logic         neg,
    output logic [W:0]   mag
);

    logic [W:0] value_ext;

    always_comb begin
        neg       = is_signed & value[W-1];
        // Sign-extend before negating so -(most negative) does not overflow.
        value_ext = {neg, value};
        mag       = neg ? (W+1)'(-value_ext) : value_ext;
    end

endmodule

// File: rtl/debug_hex_scanner.sv
// Multi-channel debug readout engine.
// Snapshots SEQ_NUM channels on sample_tick and converts them one at a time
// into sign-plus-hex display codes, written into the back half of a
// double-buffered digit store. The front half is read combinationally.
//   sys_clk, sys_rst_n  clock, asynchronous active-low reset
//   sample_tick         single-cycle snapshot/convert request
//   freeze              level; ticks are ignored while high
//   seq_in              channel c at [c*SEQ_LEN +: SEQ_LEN]
//   rd_ch, rd_digit     read select; digit 0 is the sign slot, then nibbles MS first
//   rd_code             display code from the front buffer (17 when out of range)
//   busy                conversion in progress (LOAD/EMIT/SWAP)
//   update              one-cycle pulse: new front buffer is visible
//   overrun             one-cycle pulse: a tick was dropped while busy
module debug_hex_scanner
    import debug_pkg::*;
#(
    parameter int SEQ_NUM = 4,
    parameter int SEQ_LEN = 16,
    parameter logic [SEQ_NUM-1:0] SIGNED_MASK = '1,
    parameter int ZERO_SUPPRESS = 0,
    localparam int SEQ_DIGITS = SEQ_LEN / 4 + 1,
    localparam int CH_W = (SEQ_NUM > 1) ? $clog2(SEQ_NUM) : 1,
    localparam int DIG_W = $clog2(SEQ_DIGITS)
) (
    input  logic                       sys_clk,
    input  logic                       sys_rst_n,
    input  logic                       sample_tick,
    input  logic                       freeze,
    input  logic [SEQ_NUM*SEQ_LEN-1:0] seq_in,
    input  logic [CH_W-1:0]            rd_ch,
    input  logic [DIG_W-1:0]           rd_digit,
    output logic [CODE_W-1:0]          rd_code,
    output logic                       busy,
    output logic                       update,
    output logic                       overrun
);

    scan_state_e state, state_nx;
    logic        accept;

    logic [SEQ_LEN-1:0] snap [SEQ_NUM];
    logic [CH_W-1:0]    ch;
    logic [DIG_W-1:0]   dig;
    logic               neg_r;
    logic               lead;     // still inside the run of leading zero nibbles
    logic [SEQ_LEN-1:0] nib_sr;   // magnitude, shifted left one nibble per emitted digit
    logic               front_sel;

    logic [CODE_W-1:0] buf0 [SEQ_NUM][SEQ_DIGITS];
    logic [CODE_W-1:0] buf1 [SEQ_NUM][SEQ_DIGITS];

    logic               neg_w;
    logic [SEQ_LEN:0]   mag_w;
    logic               last_dig;
    logic               last_ch;
    logic [3:0]         nib;
    logic [CODE_W-1:0]  code_w;

    debug_sign_mag #(
        .W (SEQ_LEN)
    ) u_sign_mag (
        .is_signed (SIGNED_MASK[ch]),
        .value     (snap[ch]),
        .neg       (neg_w),
        .mag       (mag_w)
    );

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        busy     = 1'b0;
        case (state)
            IDLE: begin
                if (sample_tick && !freeze) begin
                    accept   = 1'b1;
                    state_nx = LOAD;
                end
            end
            LOAD: begin
                busy     = 1'b1;
                state_nx = EMIT;
            end
            EMIT: begin
                busy = 1'b1;
                if (last_dig) begin
                    state_nx = last_ch ? SWAP : LOAD;
                end
            end
            SWAP: begin
                busy     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        last_dig = (dig == DIG_W'(SEQ_DIGITS - 1));
        last_ch  = (ch == CH_W'(SEQ_NUM - 1));
        nib      = nib_sr[SEQ_LEN-1 -: 4];
        code_w   = CODE_BLANK;
        if (dig == '0) begin
            code_w = neg_r ? CODE_MINUS : CODE_BLANK;
        end else if ((ZERO_SUPPRESS != 0) && lead && (nib == 4'h0) && !last_dig) begin
            code_w = CODE_BLANK;
        end else begin
            code_w = {1'b0, nib};
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            for (int unsigned c = 0; c < SEQ_NUM; c++) begin
                snap[c] <= '0;
            end
            ch        <= '0;
            dig       <= '0;
            neg_r     <= 1'b0;
            lead      <= 1'b0;
            nib_sr    <= '0;
            front_sel <= 1'b0;
            update    <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            update  <= (state == SWAP);
            overrun <= sample_tick & busy;
            if (state == SWAP) begin
                front_sel <= ~front_sel;
            end
            if (accept) begin
                for (int unsigned c = 0; c < SEQ_NUM; c++) begin
                    snap[c] <= seq_in[c*SEQ_LEN +: SEQ_LEN];
                end
                ch <= '0;
            end
            if (state == LOAD) begin
                neg_r  <= neg_w;
                nib_sr <= mag_w[SEQ_LEN-1:0];
                // A set bit above the displayed nibbles would make every
                // displayed zero significant.
                lead   <= ~mag_w[SEQ_LEN];
                dig    <= '0;
            end
            if (state == EMIT) begin
                dig <= dig + 1'b1;
                if (dig != '0) begin
                    nib_sr <= nib_sr << 4;
                    lead   <= lead & (nib == 4'h0);
                end
                if (last_dig && !last_ch) begin
                    ch <= ch + 1'b1;
                end
            end
        end
    end

    // Writes always target the half that is not being displayed.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            for (int unsigned c = 0; c < SEQ_NUM; c++) begin
                for (int unsigned d = 0; d < SEQ_DIGITS; d++) begin
                    buf0[c][d] <= CODE_BLANK;
                    buf1[c][d] <= CODE_BLANK;
                end
            end
        end else if (state == EMIT) begin
            if (front_sel) begin
                buf0[ch][dig] <= code_w;
            end else begin
                buf1[ch][dig] <= code_w;
            end
        end
    end

    always_comb begin
        rd_code = CODE_BLANK;
        if ((int'(rd_ch) < SEQ_NUM) && (int'(rd_digit) < SEQ_DIGITS)) begin
            rd_code = front_sel ? buf1[rd_ch][rd_digit] : buf0[rd_ch][rd_digit];
        end
    end

endmodule

// File: tb/tb_debug_hex_scanner.sv
module tb_debug_hex_scanner;

    logic        clk;
    logic        rst_n;

    logic        tick_a, freeze_a;
    logic [63:0] seq_in_a;
    logic [1:0]  rd_ch_a;
    logic [2:0]  rd_digit_a;
    logic [4:0]  rd_code_a;
    logic        busy_a, update_a, overrun_a;

    logic        tick_b, freeze_b;
    logic [47:0] seq_in_b;
    logic [1:0]  rd_ch_b;
    logic [2:0]  rd_digit_b;
    logic [4:0]  rd_code_b;
    logic        busy_b, update_b, overrun_b;

    int errors = 0;
    int checks = 0;

    debug_hex_scanner u_dut_a (
        .sys_clk     (clk),
        .sys_rst_n   (rst_n),
        .sample_tick (tick_a),
        .freeze      (freeze_a),
        .seq_in      (seq_in_a),
        .rd_ch       (rd_ch_a),
        .rd_digit    (rd_digit_a),
        .rd_code     (rd_code_a),
        .busy        (busy_a),
        .update      (update_a),
        .overrun     (overrun_a)
    );

    debug_hex_scanner #(
        .SEQ_NUM       (3),
        .SEQ_LEN       (16),
        .SIGNED_MASK   (3'b011),
        .ZERO_SUPPRESS (1)
    ) u_dut_b (
        .sys_clk     (clk),
        .sys_rst_n   (rst_n),
        .sample_tick (tick_b),
        .freeze      (freeze_b),
        .seq_in      (seq_in_b),
        .rd_ch       (rd_ch_b),
        .rd_digit    (rd_digit_b),
        .rd_code     (rd_code_b),
        .busy        (busy_b),
        .update      (update_b),
        .overrun     (overrun_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    typedef struct {
        int          dut;
        int          ch;
        logic [15:0] val;
        logic [24:0] exp;   // digit 0 in the top 5 bits
    } vec_t;

    vec_t vecs [7];

    function automatic logic [24:0] c5(input int a, input int b, input int c,
                                       input int d, input int e);
        return {5'(a), 5'(b), 5'(c), 5'(d), 5'(e)};
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic tick(input bit a, input bit b);
        tick_a = a;
        tick_b = b;
        step();
        tick_a = 1'b0;
        tick_b = 1'b0;
    endtask

    task automatic rd(input int dsel, input int c, input int d, output logic [4:0] code);
        if (dsel == 0) begin
            rd_ch_a    = 2'(c);
            rd_digit_a = 3'(d);
            #1 code = rd_code_a;
        end else begin
            rd_ch_b    = 2'(c);
            rd_digit_b = 3'(d);
            #1 code = rd_code_b;
        end
    endtask

    // First update cycle index (0 if none) for each DUT, plus A pulse counts.
    task automatic wait_upd(input int limit, output int na, output int nb,
                            output int ua, output int ova);
        na = 0; nb = 0; ua = 0; ova = 0;
        for (int n = 1; n <= limit; n++) begin
            step();
            if (update_a) begin
                ua++;
                if (na == 0) na = n;
            end
            if (update_b && nb == 0) nb = n;
            if (overrun_a) ova++;
        end
    endtask

    task automatic chk_digits(input string name, input int dsel, input int c, input logic [24:0] exp);
        logic [4:0] code;
        for (int d = 0; d < 5; d++) begin
            rd(dsel, c, d, code);
            chk($sformatf("%s_d%0d", name, d), code, exp[(4-d)*5 +: 5]);
        end
    endtask

    initial begin
        int na, nb, ua, ova;
        logic [4:0] code;
        bit seen;

        vecs[0] = '{0, 0, 16'h1234, c5(17, 1, 2, 3, 4)};
        vecs[1] = '{0, 1, 16'hFFFF, c5(16, 0, 0, 0, 1)};
        vecs[2] = '{0, 2, 16'h8000, c5(16, 8, 0, 0, 0)};
        vecs[3] = '{0, 3, 16'h0001, c5(17, 0, 0, 0, 1)};
        vecs[4] = '{1, 0, 16'h0005, c5(17, 17, 17, 17, 5)};
        vecs[5] = '{1, 1, 16'hFFF0, c5(16, 17, 17, 1, 0)};
        vecs[6] = '{1, 2, 16'h8000, c5(17, 8, 0, 0, 0)};

        rst_n = 1'b0;
        tick_a = 1'b0; freeze_a = 1'b0; seq_in_a = '0; rd_ch_a = '0; rd_digit_a = '0;
        tick_b = 1'b0; freeze_b = 1'b0; seq_in_b = '0; rd_ch_b = '0; rd_digit_b = '0;
        repeat (2) step();
        rst_n = 1'b1;
        step();

        // Reset state
        for (int c = 0; c < 4; c++) begin
            chk_digits($sformatf("reset_ch%0d", c), 0, c, c5(17, 17, 17, 17, 17));
        end
        chk("reset_busy", busy_a, 0);
        chk("reset_update", update_a, 0);
        chk("reset_overrun", overrun_a, 0);
        chk("reset_busy_b", busy_b, 0);

        // Table-driven conversion of both instances
        for (int v = 0; v < 7; v++) begin
            if (vecs[v].dut == 0) seq_in_a[vecs[v].ch*16 +: 16] = vecs[v].val;
            else                  seq_in_b[vecs[v].ch*16 +: 16] = vecs[v].val;
        end
        tick(1, 1);
        chk("busy_after_tick", busy_a, 1);
        wait_upd(40, na, nb, ua, ova);
        chk("latency_a", na, 25);
        chk("latency_b", nb, 19);
        chk("update_count_a", ua, 1);
        for (int v = 0; v < 7; v++) begin
            chk_digits($sformatf("vec%0d", v), vecs[v].dut, vecs[v].ch, vecs[v].exp);
        end
        rd(1, 3, 0, code);
        chk("oor_ch", code, 17);
        rd(0, 0, 7, code);
        chk("oor_digit", code, 17);

        // Zero value with suppression: last nibble stays visible
        seq_in_b[15:0] = 16'h0000;
        tick(0, 1);
        wait_upd(40, na, nb, ua, ova);
        chk("latency_b_zero", nb, 19);
        chk("no_update_a", ua, 0);
        chk_digits("zs_zero", 1, 0, c5(17, 17, 17, 17, 0));

        // Second tick 5 cycles after the first is dropped
        tick(1, 0);
        repeat (4) step();
        tick(1, 0);
        chk("overrun_pulse", overrun_a, 1);
        wait_upd(40, na, nb, ua, ova);
        chk("overrun_once", ova, 0);
        chk("overrun_single_update", ua, 1);

        // Tick during SWAP dropped; tick in the following cycle accepted
        tick(1, 0);
        repeat (24) step();
        chk("busy_in_swap", busy_a, 1);
        chk("no_update_in_swap", update_a, 0);
        tick_a = 1'b1;
        step();
        chk("swap_update", update_a, 1);
        chk("swap_overrun", overrun_a, 1);
        chk("swap_idle_busy", busy_a, 0);
        step();
        tick_a = 1'b0;
        chk("post_swap_accept_busy", busy_a, 1);
        chk("post_swap_no_overrun", overrun_a, 0);
        wait_upd(40, na, nb, ua, ova);
        chk("post_swap_latency", na, 25);

        // Freeze blocks ticks
        freeze_a = 1'b1;
        tick(1, 0);
        chk("freeze_busy", busy_a, 0);
        wait_upd(30, na, nb, ua, ova);
        chk("freeze_no_update", ua, 0);
        freeze_a = 1'b0;
        chk_digits("freeze_unchanged", 0, 0, vecs[0].exp);

        // Freeze rising mid-conversion does not abort
        tick(1, 0);
        repeat (5) step();
        freeze_a = 1'b1;
        wait_upd(40, na, nb, ua, ova);
        chk("freeze_mid_latency", na, 20);
        freeze_a = 1'b0;

        // Reset in the middle of a conversion
        seq_in_a[15:0] = 16'h0001;
        tick(1, 0);
        repeat (9) step();
        rst_n = 1'b0;
        #1;
        chk("midreset_busy", busy_a, 0);
        for (int c = 0; c < 4; c++) begin
            chk_digits($sformatf("midreset_ch%0d", c), 0, c, c5(17, 17, 17, 17, 17));
        end
        rst_n = 1'b1;
        step();
        tick(1, 0);
        wait_upd(40, na, nb, ua, ova);
        chk("after_reset_latency", na, 25);
        chk_digits("after_reset_ch0", 0, 0, c5(17, 0, 0, 0, 1));

        // Continuous read across the swap; seq_in changes after the snapshot
        seq_in_a[15:0] = 16'h0002;
        rd_ch_a = 2'd0;
        rd_digit_a = 3'd4;
        tick(1, 0);
        seq_in_a[15:0] = 16'h0003;
        seen = 1'b0;
        for (int n = 1; n <= 40 && !seen; n++) begin
            step();
            if (update_a) begin
                seen = 1'b1;
                chk("stream_new_digit", rd_code_a, 2);
                chk("stream_latency", n, 25);
            end else begin
                chk($sformatf("stream_old_c%0d", n), rd_code_a, 1);
            end
        end
        if (!seen) chk("stream_update_seen", 0, 1);
        chk_digits("stream_final", 0, 0, c5(17, 0, 0, 0, 2));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
